// File: rtl/bus.sv
// Single-master bus: registered grant, address decode to two slaves, registered read mux.
// Define BUS_OUTPUT_GATE_EN to force slave address/write/data to zero while ungranted.
module bus (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [15:0] m_addr,
  input  logic [63:0] m_dout,
  input  logic [63:0] s0_dout,
  input  logic [63:0] s1_dout,
  output logic        m_grant,
  output logic [63:0] m_din,
  output logic        s0_sel,
  output logic        s1_sel,
  output logic [15:0] s_addr,
  output logic        s_wr,
  output logic [63:0] s_din
);

  logic       grant_q;
  logic [1:0] rd_sel_q;
  logic       hit0;
  logic       hit1;

  // reset_n is an active-high synchronous reset despite its name
  always_ff @(posedge clk) begin
    if (reset_n) begin
      grant_q  <= 1'b0;
      rd_sel_q <= 2'b00;
    end else begin
      grant_q  <= m_req;
      rd_sel_q <= {s1_sel, s0_sel};
    end
  end

  assign m_grant = grant_q;

  assign hit0   = (m_addr[15:11] == 5'b00000);
  assign hit1   = (m_addr[15:9] == 7'b0111000);
  assign s0_sel = grant_q & hit0;
  assign s1_sel = grant_q & hit1;

`ifdef BUS_OUTPUT_GATE_EN
  assign s_addr = grant_q ? m_addr : 16'h0;
  assign s_wr   = grant_q & m_wr;
  assign s_din  = grant_q ? m_dout : 64'h0;
`else
  assign s_addr = m_addr;
  assign s_wr   = m_wr;
  assign s_din  = m_dout;
`endif

  // one-cycle read latency matches synchronous slaves
  always_comb begin
    m_din = 64'h0;
    unique case (rd_sel_q)
      2'b01:   m_din = s0_dout;
      2'b10:   m_din = s1_dout;
      default: m_din = 64'h0;
    endcase
  end

endmodule

// File: tb/tb_bus.sv
// Directed test for bus: reset, grant latency, decode, read mux, release.
// Exercises both builds via BUS_OUTPUT_GATE_EN.
module tb_bus;

  logic        clk;
  logic        reset_n;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic [63:0] s0_dout;
  logic [63:0] s1_dout;
  logic        m_grant;
  logic [63:0] m_din;
  logic        s0_sel;
  logic        s1_sel;
  logic [15:0] s_addr;
  logic        s_wr;
  logic [63:0] s_din;

  int total = 0;
  int bad   = 0;

  bus dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_req   (m_req),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_dout  (m_dout),
    .s0_dout (s0_dout),
    .s1_dout (s1_dout),
    .m_grant (m_grant),
    .m_din   (m_din),
    .s0_sel  (s0_sel),
    .s1_sel  (s1_sel),
    .s_addr  (s_addr),
    .s_wr    (s_wr),
    .s_din   (s_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seq_addr [3];
  logic        seq_s0   [3];

  initial begin
    seq_addr[0] = 16'h0000; seq_s0[0] = 1'b1;
    seq_addr[1] = 16'h7030; seq_s0[1] = 1'b0;
    seq_addr[2] = 16'h7000; seq_s0[2] = 1'b0;

    reset_n = 1'b1;
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = 16'h0;
    m_dout  = 64'h0;
    s0_dout = 64'h0F0F;
    s1_dout = 64'hF0F0;
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_grant", 64'(m_grant), 64'd0);
    chk("rst_s0", 64'(s0_sel), 64'd0);
    chk("rst_s1", 64'(s1_sel), 64'd0);
    chk("rst_din", m_din, 64'h0);

    // grant latency and slave 0 read
    m_req = 1'b1;
    #1;
    chk("grant_lat", 64'(m_grant), 64'd0);
    chk("s0_ungranted", 64'(s0_sel), 64'd0);
    step();
    chk("grant_on", 64'(m_grant), 64'd1);
    chk("rd0_s0", 64'(s0_sel), 64'd1);
    chk("rd0_s1", 64'(s1_sel), 64'd0);
    chk("rd0_din_early", m_din, 64'h0);
    step();
    chk("rd0_din", m_din, 64'h0F0F);

    // slave 1 read, top of range
    m_addr = 16'h71FF;
    #1;
    chk("rd1_s1", 64'(s1_sel), 64'd1);
    chk("rd1_s0", 64'(s0_sel), 64'd0);
    step();
    chk("rd1_din", m_din, 64'hF0F0);

    // unmapped
    m_addr = 16'h6060;
    #1;
    chk("unm_s0", 64'(s0_sel), 64'd0);
    chk("unm_s1", 64'(s1_sel), 64'd0);
    step();
    chk("unm_din", m_din, 64'h0);

    // write to top of slave 0
    m_wr   = 1'b1;
    m_addr = 16'h07FF;
    m_dout = 64'hFFFF;
    #1;
    chk("wr_s0", 64'(s0_sel), 64'd1);
    chk("wr_s1", 64'(s1_sel), 64'd0);
    chk("wr_swr", 64'(s_wr), 64'd1);
    chk("wr_saddr", 64'(s_addr), 64'h07FF);
    chk("wr_sdin", s_din, 64'hFFFF);
    step();
    chk("wr_din_mux", m_din, 64'h0F0F);

    // edge just past slave 0
    m_addr = 16'h0800;
    #1;
    chk("edge0_s0", 64'(s0_sel), 64'd0);
    m_addr = 16'h7200;
    #1;
    chk("edge1_s1", 64'(s1_sel), 64'd0);
    m_addr = 16'h07FF;

    // release: select persists while grant still high
    m_req = 1'b0;
    #1;
    chk("rel_grant_hold", 64'(m_grant), 64'd1);
    chk("rel_s0_hold", 64'(s0_sel), 64'd1);
    step();
    chk("rel_grant_off", 64'(m_grant), 64'd0);
    m_addr = 16'h00F0;
    #1;
    chk("rel_s0", 64'(s0_sel), 64'd0);
    chk("rel_s1", 64'(s1_sel), 64'd0);
`ifdef BUS_OUTPUT_GATE_EN
    chk("rel_swr", 64'(s_wr), 64'd0);
    chk("rel_saddr", 64'(s_addr), 64'h0);
    chk("rel_sdin", s_din, 64'h0);
`else
    chk("rel_swr", 64'(s_wr), 64'd1);
    chk("rel_saddr", 64'(s_addr), 64'h00F0);
    chk("rel_sdin", s_din, 64'hFFFF);
`endif
    step();
    chk("rel_din", m_din, 64'h0);

    // exclusivity sweep
    m_wr  = 1'b0;
    m_req = 1'b1;
    step();
    chk("ex_grant", 64'(m_grant), 64'd1);
    for (int i = 0; i < 3; i++) begin
      m_addr = seq_addr[i];
      #1;
      chk($sformatf("ex_s0_%0d", i), 64'(s0_sel), 64'(seq_s0[i]));
      chk($sformatf("ex_s1_%0d", i), 64'(s1_sel), 64'(!seq_s0[i]));
      chk($sformatf("ex_both_%0d", i), 64'(s0_sel & s1_sel), 64'd0);
      step();
      chk($sformatf("ex_din_%0d", i), m_din,
          seq_s0[i] ? 64'h0F0F : 64'hF0F0);
    end

    // reset abandons an in-flight transfer even with m_req held
    m_addr  = 16'h0000;
    reset_n = 1'b1;
    step();
    chk("mid_rst_grant", 64'(m_grant), 64'd0);
    chk("mid_rst_s0", 64'(s0_sel), 64'd0);
    chk("mid_rst_din", m_din, 64'h0);
    reset_n = 1'b0;
    step();
    chk("post_rst_grant", 64'(m_grant), 64'd1);
    chk("post_rst_s0", 64'(s0_sel), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus.md
BUS -- requirements
Module: bus

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset_n, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have the port m_req, input, 1 bit: master bus request.
REQ-004 The block SHALL have the port m_wr, input, 1 bit: master write enable (1 = write, 0 = read).
REQ-005 The block SHALL have the port m_addr, input, 16 bits: master address.
REQ-006 The block SHALL have the port m_dout, input, 64 bits: master write data.
REQ-007 The block SHALL have the ports s0_dout and s1_dout, input, 64 bits each: read data from slave 0 and slave 1.
REQ-008 The block SHALL have the port m_grant, output, 1 bit: bus granted to the master.
REQ-009 The block SHALL have the port m_din, output, 64 bits: read data returned to the master.
REQ-010 The block SHALL have the ports s0_sel and s1_sel, output, 1 bit each: slave 0 and slave 1 select.
REQ-011 The block SHALL have the port s_addr, output, 16 bits: address driven to the slaves.
REQ-012 The block SHALL have the port s_wr, output, 1 bit: write enable driven to the slaves.
REQ-013 The block SHALL have the port s_din, output, 64 bits: write data driven to the slaves.

Function
REQ-014 m_grant SHALL be a register: m_grant <= m_req each cycle, giving one cycle of grant latency; deassertion also takes effect one cycle later.
REQ-015 Decode SHALL be combinational and gated by m_grant.
REQ-016 Slave 0 range SHALL be m_addr 0x0000-0x07FF (m_addr[15:11]==5'b00000); in range -> s0_sel=1.
REQ-017 Slave 1 range SHALL be m_addr 0x7000-0x71FF (m_addr[15:9]==7'b0111000); in range -> s1_sel=1.
REQ-018 Any other address, or m_grant=0, SHALL give s0_sel=s1_sel=0.
REQ-019 s0_sel and s1_sel SHALL never be 1 simultaneously.
REQ-020 s_addr=m_addr, s_wr=m_wr and s_din=m_dout SHALL pass through combinationally (subject to REQ-027).
REQ-021 A 2-bit read-select register SHALL capture {s1_sel,s0_sel} every cycle.
REQ-022 m_din SHALL be s0_dout when the registered select = 01, s1_dout when it = 10, and 64'h0 otherwise, giving one cycle of read latency to match synchronous slaves.
REQ-023 m_din SHALL follow the mux independently of m_wr.
REQ-024 When m_req drops, selects SHALL remain active for the one cycle in which m_grant is still 1; the cycle after, all selects SHALL be 0.

Reset
REQ-025 While reset_n=1 at a rising clk, m_grant SHALL be set to 0 and the read-select register to 00, so s0_sel=s1_sel=0 and m_din=0 from the next cycle.
REQ-026 Reset SHALL override m_req in that cycle; an in-flight transfer is abandoned with no further selects until a new grant.

Configuration
REQ-027 With macro BUS_OUTPUT_GATE_EN defined, s_addr, s_wr and s_din SHALL be forced to 0 whenever m_grant=0; without it, they SHALL pass through unconditionally.

Verification
REQ-028 Reset check: reset_n=1 for 1 cycle, m_req=0 -> m_grant=0, s0_sel=s1_sel=0, m_din=0.
REQ-029 Grant and slave 0 read: m_req=1, m_addr=0x0000, m_wr=0, s0_dout=0x0F0F -> m_grant=1 after 1 cycle, s0_sel=1, m_din=0x0F0F the following cycle.
REQ-030 Slave 1 read and unmapped address: with grant held, m_addr=0x71FF -> s1_sel=1, m_din=0xF0F0 next cycle; then m_addr=0x6060 -> no select, m_din=0 next cycle.
REQ-031 Write to slave 0: m_wr=1, m_addr=0x07FF, m_dout=0xFFFF -> s0_sel=1, s_wr=1, s_addr=0x07FF, s_din=0xFFFF.
REQ-032 Request release: m_req=0 -> m_grant=0 one cycle later; m_addr=0x00F0 then -> no select (with BUS_OUTPUT_GATE_EN: s_wr=0, s_addr=0).
REQ-033 Select exclusivity: alternate m_addr 0x0000/0x7030/0x7000 with grant held -> exactly one select each cycle, never both.
